// File: rtl/divider_pkg.sv
// Shared types and constants for the iterative restoring divider.
package divider_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the divisor.
module divider_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH:0]   diff;
  logic             no_borrow;

  always_comb begin
    rem_sh    = {rem_i, quo_i[WIDTH-1]};
    no_borrow = (rem_sh >= {2'b00, divisor_i});
    // Only taken when no borrow, so the low WIDTH+1 bits hold the exact difference.
    diff      = rem_sh[WIDTH:0] - {1'b0, divisor_i};
    rem_o     = no_borrow ? diff : rem_sh[WIDTH:0];
    quo_o     = {quo_i[WIDTH-2:0], no_borrow};
  end

endmodule

// File: rtl/divider_32x32.sv
// Iterative 32x32 restoring divider with valid/ready handshakes on both sides.
// Optional signed operation is enabled by defining DIVIDER_SIGNED_EN.
module divider_32x32
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               dbz_q, dbz_d;
  logic               in_ready_q;

  logic [WIDTH:0]     step_rem;
  logic [WIDTH-1:0]   step_quo;
  logic [WIDTH-1:0]   dividend_mag, divisor_mag;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               accept;

  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  assign accept = in_valid && in_ready_q;

`ifdef DIVIDER_SIGNED_EN
  logic q_neg_q, r_neg_q;

  assign dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign quo_fix      = q_neg_q ? -step_quo : step_quo;
  assign rem_fix      = r_neg_q ? -step_rem[WIDTH-1:0] : step_rem[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else if (state_q == IDLE && accept) begin
      q_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_neg_q <= dividend[WIDTH-1];
    end
  end
`else
  assign dividend_mag = dividend;
  assign divisor_mag  = divisor;
  assign quo_fix      = step_quo;
  assign rem_fix      = step_rem[WIDTH-1:0];
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = DONE;
          end else begin
            rem_d   = '0;
            cnt_d   = '0;
            quo_d   = dividend_mag;
            dvs_d   = divisor_mag;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        // The last iteration writes the (sign-fixed) result straight into the output registers.
        if (cnt_q == CNT_LAST) begin
          quotient_d  = quo_fix;
          remainder_d = rem_fix;
          dbz_d       = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      // Registered ready keeps in_ready low throughout reset and free of input paths.
      in_ready_q  <= (state_d == IDLE);
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_32x32.sv
// Self-checking bench for divider_32x32 against a plain-arithmetic reference model.
module tb_divider_32x32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  divider_32x32 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish required=finish");
    $fatal(1, "watchdog");
  end

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic dz);
    dz = (b == 32'd0);
    if (dz) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
`ifdef DIVIDER_SIGNED_EN
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
`else
      q = a / b;
      r = a % b;
`endif
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, output int acc_cyc);
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL start_op_ready_timeout in_ready=%0b required=1", in_ready);
    end
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    acc_cyc  = cyc;
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (!out_valid && edges < 100) begin
      tick();
      edges++;
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output logic dz,
                       output int edges, output int acc_cyc);
    start_op(a, b, acc_cyc);
    wait_valid(edges);
    q  = quotient;
    r  = remainder;
    dz = div_by_zero;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b required=0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b required=0", out_valid); end
    checks++;
    if (quotient !== 32'd0 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%h/%h/%0b required=0/0/0", quotient, remainder, div_by_zero);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%0b required=1", in_ready); end
  endtask

  task automatic test_basic();
    logic [31:0] ta [3] = '{32'd100, 32'hFFFF_FFFF, 32'd5};
    logic [31:0] tb [3] = '{32'd7,   32'd1,         32'd9};
    logic [31:0] eq [3] = '{32'd14,  32'hFFFF_FFFF, 32'd0};
    logic [31:0] er [3] = '{32'd2,   32'd0,         32'd5};
    logic [31:0] q, r;
    logic dz;
    int edges, acc;
    for (int i = 0; i < 3; i++) begin
      do_op(ta[i], tb[i], q, r, dz, edges, acc);
      $display("basic %0d / %0d -> q=%0d r=%0d dz=%0b lat=%0d", ta[i], tb[i], q, r, dz, edges);
      checks++;
      if (q !== eq[i] || r !== er[i] || dz !== 1'b0) begin
        failures++;
        $display("FAIL basic_result got=%h/%h/%0b required=%h/%h/0", q, r, dz, eq[i], er[i]);
      end
      checks++;
      if (edges != 32) begin failures++; $display("FAIL basic_latency got=%0d required=32", edges); end
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_after got=%0b required=1", in_ready); end
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] q, r;
    logic dz;
    int edges, acc;
    do_op(32'd1234, 32'd0, q, r, dz, edges, acc);
    $display("div_zero 1234 / 0 -> q=%h r=%0d dz=%0b lat=%0d", q, r, dz, edges);
    checks++;
    if (q !== 32'hFFFF_FFFF || r !== 32'd1234 || dz !== 1'b1) begin
      failures++;
      $display("FAIL div_zero_result got=%h/%h/%0b required=ffffffff/000004d2/1", q, r, dz);
    end
    checks++;
    if (edges != 0) begin failures++; $display("FAIL div_zero_latency got=%0d required=0", edges); end
  endtask

  task automatic test_backpressure();
    int edges, acc;
    int seen = 0;
    start_op(32'd1000, 32'd3, acc);
    wait_valid(edges);
    checks++;
    if (edges != 32) begin failures++; $display("FAIL bp_latency got=%0d required=32", edges); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || quotient !== 32'd333 || remainder !== 32'd1 ||
          div_by_zero !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got=v%0b q%0d r%0d z%0b rdy%0b required=v1 q333 r1 z0 rdy0",
                 i, out_valid, quotient, remainder, div_by_zero, in_ready);
      end
      if (i == 1) begin
        dividend = 32'd7;
        divisor  = 32'd7;
        in_valid = 1'b1;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    $display("backpressure 1000 / 3 released, in_ready=%0b out_valid=%0b", in_ready, out_valid);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release got=rdy%0b v%0b required=rdy1 v0", in_ready, out_valid);
    end
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1;
      tick();
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL bp_ignored_input got=%0d required=0", seen); end
  endtask

  task automatic test_reset_mid();
    int acc;
    int seen = 0;
    start_op(32'd50000, 32'd7, acc);
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_low got=rdy%0b v%0b required=rdy0 v0", in_ready, out_valid);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_ready got=%0b required=1", in_ready); end
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1;
      tick();
    end
    $display("reset_mid 50000 / 7 aborted, out_valid_seen=%0d", seen);
    checks++;
    if (seen != 0) begin failures++; $display("FAIL mid_reset_out_valid got=%0d required=0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q, r, eq, er;
    logic dz, edz;
    int edges, a1, a2;
    do_op(32'd1000, 32'd3, q, r, dz, edges, a1);
    do_op(32'd77, 32'd5, q, r, dz, edges, a2);
    model(32'd77, 32'd5, eq, er, edz);
    $display("b2b normal accept spacing=%0d q=%0d r=%0d", a2 - a1, q, r);
    checks++;
    if (a2 - a1 != 34) begin failures++; $display("FAIL b2b_normal_spacing got=%0d required=34", a2 - a1); end
    checks++;
    if (q !== eq || r !== er || dz !== edz) begin
      failures++;
      $display("FAIL b2b_result got=%h/%h/%0b required=%h/%h/%0b", q, r, dz, eq, er, edz);
    end
    do_op(32'd9, 32'd0, q, r, dz, edges, a1);
    do_op(32'd10, 32'd0, q, r, dz, edges, a2);
    $display("b2b div_zero accept spacing=%0d r=%0d", a2 - a1, r);
    checks++;
    if (a2 - a1 != 2) begin failures++; $display("FAIL b2b_dz_spacing got=%0d required=2", a2 - a1); end
    checks++;
    if (r !== 32'd10 || dz !== 1'b1) begin
      failures++;
      $display("FAIL b2b_dz_result got=%h/%0b required=0000000a/1", r, dz);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, q, r, eq, er;
    logic dz, edz;
    int edges, acc;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom_range(1, 255);
        2: b = (i % 8 == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
        default: b = a >> $urandom_range(0, 4);
      endcase
      model(a, b, eq, er, edz);
      do_op(a, b, q, r, dz, edges, acc);
      $display("random %h / %h -> q=%h r=%h dz=%0b lat=%0d", a, b, q, r, dz, edges);
      checks++;
      if (q !== eq) begin failures++; $display("FAIL rand_quotient got=%h required=%h", q, eq); end
      checks++;
      if (r !== er) begin failures++; $display("FAIL rand_remainder got=%h required=%h", r, er); end
      checks++;
      if (dz !== edz) begin failures++; $display("FAIL rand_dbz got=%0b required=%0b", dz, edz); end
      checks++;
      if (edges != (edz ? 0 : 32)) begin
        failures++;
        $display("FAIL rand_latency got=%0d required=%0d", edges, edz ? 0 : 32);
      end
    end
  endtask

`ifdef DIVIDER_SIGNED_EN
  task automatic test_signed();
    logic [31:0] q, r;
    logic dz;
    int edges, acc;
    do_op(-32'sd100, 32'd7, q, r, dz, edges, acc);
    $display("signed -100 / 7 -> q=%h r=%h", q, r);
    checks++;
    if (q !== 32'hFFFF_FFF2 || r !== 32'hFFFF_FFFE || dz !== 1'b0) begin
      failures++;
      $display("FAIL signed_neg got=%h/%h/%0b required=fffffff2/fffffffe/0", q, r, dz);
    end
    do_op(32'h8000_0000, 32'hFFFF_FFFF, q, r, dz, edges, acc);
    $display("signed 80000000 / ffffffff -> q=%h r=%h", q, r);
    checks++;
    if (q !== 32'h8000_0000 || r !== 32'd0 || dz !== 1'b0) begin
      failures++;
      $display("FAIL signed_overflow got=%h/%h/%0b required=80000000/00000000/0", q, r, dz);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef DIVIDER_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
